cyc10_decoder: RTL and testbench

Registered streaming decoder for the team's 4-bit decimal cyclic (unit-distance) code. The code maps digits 0..9 to 0,1,3,2,6,E,A,B,9,8 (hex).
- Accepts code words over a valid/ready handshake.
- Returns the decimal digit, an invalid-code flag and a saturating error count.
- Sits downstream of the digit-to-code encoder, e.g. on a sensor or link receive path.

---
 rtl/cyc10_pkg.sv | 47 ++++
 rtl/cyc10_lut.sv | 29 ++
 rtl/cyc10_decoder.sv | 111 +++++++++++
 tb/tb_cyc10_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cyc10_pkg.sv
// Shared types and constants for the decimal cyclic (unit-distance) code,
// used by the decoder and the encoder.
package cyc10_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [3:0] CYC10_CODE_0 = 4'h0;
    localparam logic [3:0] CYC10_CODE_1 = 4'h1;
    localparam logic [3:0] CYC10_CODE_2 = 4'h3;
    localparam logic [3:0] CYC10_CODE_3 = 4'h2;
    localparam logic [3:0] CYC10_CODE_4 = 4'h6;
    localparam logic [3:0] CYC10_CODE_5 = 4'hE;
    localparam logic [3:0] CYC10_CODE_6 = 4'hA;
    localparam logic [3:0] CYC10_CODE_7 = 4'hB;
    localparam logic [3:0] CYC10_CODE_8 = 4'h9;
    localparam logic [3:0] CYC10_CODE_9 = 4'h8;

    localparam digit_t DIGIT_INVALID = 4'hF;

    localparam logic [1:0] STEP_NONE = 2'b00;
    localparam logic [1:0] STEP_INC  = 2'b01;
    localparam logic [1:0] STEP_DEC  = 2'b10;
    localparam logic [1:0] STEP_JUMP = 2'b11;

    // Step from last to cur on the decimal ring, so 9->0 is +1 and 0->9 is -1.
    function automatic logic [1:0] step_of(input digit_t cur, input digit_t last);
        logic [4:0] diff;
        logic [1:0] step;
        diff = {1'b0, cur} + 5'd10 - {1'b0, last};
        if (diff >= 5'd10) begin
            diff = diff - 5'd10;
        end
        case (diff)
            5'd0:    step = STEP_NONE;
            5'd1:    step = STEP_INC;
            5'd9:    step = STEP_DEC;
            default: step = STEP_JUMP;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/cyc10_lut.sv
// Combinational cyclic-code to digit lookup; the six unused codes return
// DIGIT_INVALID with err_o set.
module cyc10_lut
    import cyc10_pkg::*;
(
    input  logic [3:0] code_i,
    output digit_t     digit_o,
    output logic       err_o
);

    always_comb begin
        digit_o = DIGIT_INVALID;
        err_o   = 1'b1;
        case (code_i)
            CYC10_CODE_0: begin digit_o = 4'd0; err_o = 1'b0; end
            CYC10_CODE_1: begin digit_o = 4'd1; err_o = 1'b0; end
            CYC10_CODE_2: begin digit_o = 4'd2; err_o = 1'b0; end
            CYC10_CODE_3: begin digit_o = 4'd3; err_o = 1'b0; end
            CYC10_CODE_4: begin digit_o = 4'd4; err_o = 1'b0; end
            CYC10_CODE_5: begin digit_o = 4'd5; err_o = 1'b0; end
            CYC10_CODE_6: begin digit_o = 4'd6; err_o = 1'b0; end
            CYC10_CODE_7: begin digit_o = 4'd7; err_o = 1'b0; end
            CYC10_CODE_8: begin digit_o = 4'd8; err_o = 1'b0; end
            CYC10_CODE_9: begin digit_o = 4'd9; err_o = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/cyc10_decoder.sv
// Registered valid/ready decoder for the decimal cyclic code with a saturating
// invalid-code counter. Step checking is added when CYC10_STEP_CHECK_EN is defined.
//
// state    | meaning
// ST_EMPTY | output register holds no result, out_valid=0
// ST_FULL  | output register holds a result, out_valid=1
module cyc10_decoder
    import cyc10_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_digit,
    output logic                 out_err,
`ifdef CYC10_STEP_CHECK_EN
    output logic [1:0]           out_step,
    output logic [ERR_CNT_W-1:0] jump_cnt,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_e                state_q, state_d;
    digit_t                digit_q;
    logic                  err_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    digit_t                lut_digit;
    logic                  lut_err;
    logic                  accept;

    cyc10_lut u_lut (
        .code_i  (in_code),
        .digit_o (lut_digit),
        .err_o   (lut_err)
    );

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            digit_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                digit_q <= lut_digit;
                err_q   <= lut_err;
                if (lut_err && !(&err_cnt_q)) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign out_digit = digit_q;
    assign out_err   = err_q;
    assign err_cnt   = err_cnt_q;

`ifdef CYC10_STEP_CHECK_EN
    digit_t               last_digit_q;
    logic                 has_last_q;
    logic [1:0]           step_q;
    logic [ERR_CNT_W-1:0] jump_cnt_q;
    logic [1:0]           step_new;

    assign step_new = has_last_q ? step_of(lut_digit, last_digit_q) : STEP_NONE;

    // Invalid codes report no step and leave the reference digit untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_digit_q <= '0;
            has_last_q   <= 1'b0;
            step_q       <= STEP_NONE;
            jump_cnt_q   <= '0;
        end else if (accept) begin
            if (lut_err) begin
                step_q <= STEP_NONE;
            end else begin
                step_q       <= step_new;
                last_digit_q <= lut_digit;
                has_last_q   <= 1'b1;
                if (step_new == STEP_JUMP && !(&jump_cnt_q)) begin
                    jump_cnt_q <= jump_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign out_step = step_q;
    assign jump_cnt = jump_cnt_q;
`endif

endmodule

// File: tb/tb_cyc10_decoder.sv
// Bench for cyc10_decoder: directed sequences then random traffic, checked
// cycle by cycle against a table-driven reference model.
module tb_cyc10_decoder;

    localparam int W      = 3;
    localparam int CNTMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_code;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_digit;
    logic         out_err;
    logic [W-1:0] err_cnt;
`ifdef CYC10_STEP_CHECK_EN
    logic [1:0]   out_step;
    logic [W-1:0] jump_cnt;
`endif

    always #5 clk = ~clk;

    cyc10_decoder #(.ERR_CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_err   (out_err),
`ifdef CYC10_STEP_CHECK_EN
        .out_step  (out_step),
        .jump_cnt  (jump_cnt),
`endif
        .err_cnt   (err_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int codes [10] = '{0, 1, 3, 2, 6, 14, 10, 11, 9, 8};
    int bad   [6]  = '{4, 5, 7, 12, 13, 15};

    bit m_valid;
    int m_digit, m_err, m_cnt, m_last, m_has, m_step, m_jump;

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int decode(input int c);
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_digit = 0; m_err = 0; m_cnt = 0;
        m_last = 0; m_has = 0; m_step = 0; m_jump = 0;
    endtask

    // One clock: drive at negedge, predict, then compare at the next negedge.
    task automatic cyc(input bit r, input bit v, input int code, input bit ord);
        bit exp_ready;
        int d, diff;
        rst = r; in_valid = v; in_code = code[3:0]; out_ready = ord;
        #1;
        exp_ready = !m_valid || ord;
        check_val("in_ready", int'(in_ready), int'(exp_ready));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (v && exp_ready) begin
            d = decode(code);
            m_valid = 1'b1;
            if (d < 0) begin
                m_digit = 15; m_err = 1; m_step = 0;
                if (m_cnt < CNTMAX) m_cnt++;
            end else begin
                m_digit = d; m_err = 0;
                if (m_has != 0) begin
                    diff = (d - m_last + 10) % 10;
                    m_step = (diff == 0) ? 0 : (diff == 1) ? 1 : (diff == 9) ? 2 : 3;
                    if (m_step == 3 && m_jump < CNTMAX) m_jump++;
                end else begin
                    m_step = 0;
                end
                m_last = d; m_has = 1;
            end
        end else if (ord) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_val("out_valid", int'(out_valid), int'(m_valid));
        check_val("out_digit", int'(out_digit), m_digit);
        check_val("out_err",   int'(out_err),   m_err);
        check_val("err_cnt",   int'(err_cnt),   m_cnt);
`ifdef CYC10_STEP_CHECK_EN
        check_val("out_step",  int'(out_step),  m_step);
        check_val("jump_cnt",  int'(jump_cnt),  m_jump);
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = 4'h0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_digit", int'(out_digit), 0);
        check_val("rst_out_err",   int'(out_err),   0);
        check_val("rst_err_cnt",   int'(err_cnt),   0);

        // valid codes back to back
        for (int i = 0; i < 10; i++) cyc(0, 1, codes[i], 1);
        cyc(0, 0, 0, 1);
        check_val("valid_err_cnt", int'(err_cnt), 0);

        // invalid codes, then saturation
        for (int i = 0; i < 6; i++) cyc(0, 1, bad[i], 1);
        check_val("six_invalid", int'(err_cnt), 6);
        for (int i = 0; i < 9; i++) cyc(0, 1, bad[i % 6], 1);
        check_val("err_cnt_sat", int'(err_cnt), CNTMAX);
        cyc(0, 0, 0, 1);

        // backpressure
        cyc(0, 1, 6, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 10, 0);
        check_val("bp_hold_digit", int'(out_digit), 4);
        cyc(0, 1, 10, 1);
        check_val("bp_release_digit", int'(out_digit), 6);
        cyc(0, 0, 0, 1);

        // reset while full with an offered word
        cyc(0, 1, 3, 0);
        cyc(1, 1, 2, 0);
        check_val("rst_mid_valid", int'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check_val("rst_mid_dropped", int'(out_valid), 0);

        // digit walk 8,9,0,9,4 and with an invalid code inserted
        cyc(1, 0, 0, 1);
        cyc(0, 1, 9, 1); cyc(0, 1, 8, 1); cyc(0, 1, 0, 1);
        cyc(0, 1, 8, 1); cyc(0, 1, 6, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 1, 9, 1); cyc(0, 1, 8, 1); cyc(0, 1, 0, 1);
        cyc(0, 1, 4, 1); cyc(0, 1, 8, 1); cyc(0, 1, 6, 1);
        cyc(0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 49) == 0, ($urandom % 4) != 0,
                int'($urandom_range(0, 15)), ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
